// File: rtl/imem_loader.sv
// imem_loader
// Boot-time instruction-memory loader. Receives a byte stream consisting of
// a 16-bit little-endian word count N followed by N little-endian 32-bit
// instruction words. It writes each word to instruction memory starting at
// BASE_ADDR, and holds the CPU program counter frozen while the load runs.
//
// Optional feature (compile-time macro IMEM_LOADER_CHECKSUM_EN):
//   When the macro is defined, one extra byte follows the data. That byte
//   must equal the modulo-256 sum of all data bytes; the length bytes are
//   not part of the sum. A mismatch ends the load in the error state.
//
// Parameters:
//   BASE_ADDR  - byte address of the first instruction word
//   MAX_WORDS  - largest accepted word count; a larger N aborts the load
//
// Ports:
//   clk        - sole clock, rising edge
//   reset      - synchronous active-low reset
//   start      - one-cycle load request (honoured in IDLE/DONE/ERR only)
//   byte_in    - program byte stream
//   byte_valid - byte_in holds a byte
//   byte_ready - loader accepts a byte this cycle
//   wr_en      - instruction-memory write strobe (one cycle per word)
//   wr_addr    - word-aligned byte address for the write
//   wr_data    - instruction word for the write
//   cpu_hold   - freezes the core while a load is in progress
//   done       - sticky: load completed
//   error      - sticky: load aborted
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK  = 3'd5,
`endif
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    // State entered once the data phase (or an empty program) completes.
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t ST_FINAL = ST_CHECK;
`else
    localparam state_t ST_FINAL = ST_DONE;
`endif

    localparam logic [16:0] MAX_WORDS_C = MAX_WORDS[16:0];

    state_t        state_r;
    state_t        state_next_s;

    logic          byte_ready_r;
    logic          wr_en_r;
    logic          cpu_hold_r;
    logic          done_r;
    logic          error_r;
    logic [31:0]   wr_addr_r;
    logic [31:0]   wr_data_r;

    logic [7:0]    len_lo_r;
    logic [15:0]   word_cnt_r;
    logic [1:0]    byte_cnt_r;
    logic [23:0]   word_buf_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    sum_r;
`endif

    logic          accept_s;
    logic [15:0]   len_s;

    assign accept_s = byte_valid & byte_ready_r;
    assign len_s    = {byte_in, len_lo_r};

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; a missing byte simply leaves the state unchanged.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_next_s = ST_LEN_LO;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_LEN_LO: begin
                if (accept_s) begin
                    state_next_s = ST_LEN_HI;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_LEN_HI: begin
                if (!accept_s) begin
                    state_next_s = state_r;
                end else if (len_s == 16'd0) begin
                    state_next_s = ST_FINAL;
                end else if ({1'b0, len_s} > MAX_WORDS_C) begin
                    state_next_s = ST_ERR;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept_s && (byte_cnt_r == 2'd3)) begin
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_WRITE: begin
                // word_cnt_r still holds the count before this write.
                if (word_cnt_r == 16'd1) begin
                    state_next_s = ST_FINAL;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (!accept_s) begin
                    state_next_s = state_r;
                end else if (byte_in == sum_r) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_ERR;
                end
            end
`endif
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Status outputs registered from the next state, so they line up with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            byte_ready_r <= 1'b0;
            wr_en_r      <= 1'b0;
            cpu_hold_r   <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            byte_ready_r <= (state_next_s == ST_LEN_LO) || (state_next_s == ST_LEN_HI) ||
`ifdef IMEM_LOADER_CHECKSUM_EN
                            (state_next_s == ST_CHECK) ||
`endif
                            (state_next_s == ST_DATA);
            wr_en_r      <= (state_next_s == ST_WRITE);
            cpu_hold_r   <= (state_next_s != ST_IDLE) && (state_next_s != ST_DONE) &&
                            (state_next_s != ST_ERR);
            done_r       <= (state_next_s == ST_DONE);
            error_r      <= (state_next_s == ST_ERR);
        end
    end

    // Datapath: length capture, word assembly, address/count stepping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_addr_r  <= BASE_ADDR;
            wr_data_r  <= 32'h0000_0000;
            len_lo_r   <= 8'h00;
            word_cnt_r <= 16'h0000;
            byte_cnt_r <= 2'd0;
            word_buf_r <= 24'h00_0000;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_r      <= 8'h00;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        wr_addr_r  <= BASE_ADDR;
                        word_cnt_r <= 16'h0000;
                        byte_cnt_r <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_r      <= 8'h00;
`endif
                    end
                end
                ST_LEN_LO: begin
                    if (accept_s) begin
                        len_lo_r <= byte_in;
                    end
                end
                ST_LEN_HI: begin
                    if (accept_s) begin
                        word_cnt_r <= len_s;
                    end
                end
                ST_DATA: begin
                    if (accept_s) begin
                        byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_r      <= sum_r + byte_in;
`endif
                        case (byte_cnt_r)
                            2'd0:    word_buf_r[7:0]   <= byte_in;
                            2'd1:    word_buf_r[15:8]  <= byte_in;
                            2'd2:    word_buf_r[23:16] <= byte_in;
                            default: wr_data_r         <= {byte_in, word_buf_r};
                        endcase
                    end
                end
                ST_WRITE: begin
                    wr_addr_r  <= wr_addr_r + 32'd4;
                    word_cnt_r <= word_cnt_r - 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // The strobe is also masked by reset so nothing is written in a reset cycle.
    assign wr_en      = wr_en_r & reset;
    assign byte_ready = byte_ready_r;
    assign cpu_hold   = cpu_hold_r;
    assign done       = done_r;
    assign error      = error_r;
    assign wr_addr    = wr_addr_r;
    assign wr_data    = wr_data_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader (default parameters).
// Covers the build with or without IMEM_LOADER_CHECKSUM_EN defined.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];

    imem_loader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every cycle with wr_en high logs one write.
    always @(negedge clk) begin
        if (wr_en) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (!(done || error) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("end_timeout", {31'd0, done | error}, 32'd1);
    endtask

    task automatic clear_q();
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
        chk({tag, "_wr_en"},      {31'd0, wr_en},      32'd0);
        chk({tag, "_cpu_hold"},   {31'd0, cpu_hold},   32'd0);
        chk({tag, "_done"},       {31'd0, done},       32'd0);
        chk({tag, "_error"},      {31'd0, error},      32'd0);
        chk({tag, "_wr_addr"},    wr_addr,             32'h0000_0000);
        chk({tag, "_wr_data"},    wr_data,             32'h0000_0000);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b1;   // must be ignored while reset is low
        byte_in    = 8'h00;
        byte_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk_idle_reset("reset");
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("idle_after_reset_byte_ready", {31'd0, byte_ready}, 32'd0);

        // Basic load: N=2
        clear_q();
        pulse_start();
        chk("basic_cpu_hold", {31'd0, cpu_hold},   32'd1);
        chk("basic_ready",    {31'd0, byte_ready}, 32'd1);
        chk("basic_addr0",    wr_addr,             32'h0000_0000);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'hA0); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h60);
`endif
        wait_end();
        repeat (2) @(negedge clk);
        chk("basic_nwrites", wq_addr.size(), 32'd2);
        if (wq_addr.size() == 2) begin
            chk("basic_w0_addr", wq_addr[0], 32'h0000_0000);
            chk("basic_w0_data", wq_data[0], 32'h00A0_0513);
            chk("basic_w1_addr", wq_addr[1], 32'h0000_0004);
            chk("basic_w1_data", wq_data[1], 32'h0010_0593);
        end
        chk("basic_done",     {31'd0, done},       32'd1);
        chk("basic_error",    {31'd0, error},      32'd0);
        chk("basic_cpu_hold_end", {31'd0, cpu_hold}, 32'd0);
        chk("basic_ready_end",    {31'd0, byte_ready}, 32'd0);
        chk("basic_data_hold",    wr_data, 32'h0010_0593);
        chk("basic_addr_after",   wr_addr, 32'h0000_0008);

        // Stall then reset mid-word
        clear_q();
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB);
        repeat (10) @(negedge clk);
        chk("stall_ready",    {31'd0, byte_ready}, 32'd1);
        chk("stall_cpu_hold", {31'd0, cpu_hold},   32'd1);
        chk("stall_done",     {31'd0, done | error}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk_idle_reset("stall_reset");
        chk("stall_nwrites", wq_addr.size(), 32'd0);
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h38);
`endif
        wait_end();
        repeat (2) @(negedge clk);
        chk("reload_nwrites", wq_addr.size(), 32'd1);
        if (wq_addr.size() == 1) begin
            chk("reload_addr", wq_addr[0], 32'h0000_0000);
            chk("reload_data", wq_data[0], 32'hDEAD_BEEF);
        end
        chk("reload_done", {31'd0, done}, 32'd1);

        // Zero length, started from DONE
        clear_q();
        pulse_start();
        chk("restart_done_clr", {31'd0, done}, 32'd0);
        chk("restart_addr",     wr_addr,       32'h0000_0000);
        send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("zero_wait_check", {31'd0, done},       32'd0);
        chk("zero_check_rdy",  {31'd0, byte_ready}, 32'd1);
        send_byte(8'h00);
`endif
        chk("zero_done",  {31'd0, done},  32'd1);
        chk("zero_error", {31'd0, error}, 32'd0);
        repeat (2) @(negedge clk);
        chk("zero_nwrites", wq_addr.size(), 32'd0);

        // Busy start ignored during DATA
        clear_q();
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        pulse_start();
        send_byte(8'h33); send_byte(8'h44);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'hAA);
`endif
        wait_end();
        repeat (2) @(negedge clk);
        chk("busy_nwrites", wq_addr.size(), 32'd1);
        if (wq_addr.size() == 1) begin
            chk("busy_addr", wq_addr[0], 32'h0000_0000);
            chk("busy_data", wq_data[0], 32'h4433_2211);
        end
        chk("busy_done", {31'd0, done}, 32'd1);

        // Over length: N=257
        clear_q();
        pulse_start();
        send_byte(8'h01); send_byte(8'h01);
        chk("over_error", {31'd0, error},      32'd1);
        chk("over_done",  {31'd0, done},       32'd0);
        chk("over_ready", {31'd0, byte_ready}, 32'd0);
        chk("over_hold",  {31'd0, cpu_hold},   32'd0);
        repeat (2) @(negedge clk);
        chk("over_nwrites", wq_addr.size(), 32'd0);

        // Boundary N=256 is accepted (started from ERR), then aborted by reset
        pulse_start();
        chk("maxlen_err_clr", {31'd0, error}, 32'd0);
        send_byte(8'h00); send_byte(8'h01);
        chk("maxlen_error", {31'd0, error},      32'd0);
        chk("maxlen_ready", {31'd0, byte_ready}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("maxlen_reset_hold", {31'd0, cpu_hold}, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match
        clear_q();
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h0A);
        wait_end();
        chk("ck_ok_done",  {31'd0, done},  32'd1);
        chk("ck_ok_error", {31'd0, error}, 32'd0);
        // Checksum mismatch
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h0B);
        wait_end();
        chk("ck_bad_error", {31'd0, error}, 32'd1);
        chk("ck_bad_done",  {31'd0, done},  32'd0);
        repeat (2) @(negedge clk);
        chk("ck_nwrites", wq_addr.size(), 32'd2);
        if (wq_addr.size() == 2) begin
            chk("ck_w0_data", wq_data[0], 32'h0403_0201);
            chk("ck_w1_data", wq_data[1], 32'h0403_0201);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameters SHALL be:
- BASE_ADDR, default 32'h0000_0000, byte address of the first instruction word.
- MAX_WORDS, default 256, largest accepted program length in words.

REQ-002 Ports SHALL be as listed below.

| Name | Direction | Width | Meaning |
|---|---|---|---|
| clk | input | 1 | sole clock; all state changes on the rising edge |
| reset | input | 1 | synchronous, active-low reset |
| start | input | 1 | one-cycle request to begin a load |
| byte_in | input | 8 | incoming program byte stream |
| byte_valid | input | 1 | byte_in holds a byte |
| byte_ready | output | 1 | loader can take a byte; transfer occurs when byte_valid and byte_ready are both high at a clock edge |
| wr_en | output | 1 | instruction-memory write strobe |
| wr_addr | output | 32 | instruction-memory byte address, word aligned |
| wr_data | output | 32 | instruction word to write |
| cpu_hold | output | 1 | keeps the core's program counter frozen while loading |
| done | output | 1 | load completed successfully; sticky |
| error | output | 1 | load aborted; sticky |

Function
REQ-003 The FSM states SHALL be IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE and ERR; CHECK exists only per REQ-020.
REQ-004 From IDLE, DONE or ERR, start=1 SHALL cause the following on the next edge:
- go to LEN_LO;
- clear done and error;
- set cpu_hold=1;
- set wr_addr=BASE_ADDR.
REQ-005 In LEN_LO, LEN_HI and DATA the loader SHALL assert byte_ready; in all other states byte_ready SHALL be 0.
REQ-006 The first two accepted bytes SHALL form a 16-bit word count N, low byte first.
REQ-007 The LEN_HI exit SHALL follow this priority:
- N=0: go to DONE (or to CHECK if REQ-020 applies).
- N>MAX_WORDS: go to ERR.
- Otherwise: go to DATA.
REQ-008 In DATA, bytes SHALL be assembled little-endian: the 1st accepted byte goes to bits [7:0] and the 4th to bits [31:24].
REQ-009 On the edge accepting the 4th byte of a word, the FSM SHALL enter WRITE.
REQ-010 In WRITE, wr_en SHALL be 1 for exactly one cycle, with wr_data equal to the assembled word and wr_addr equal to the current address.
REQ-011 On the edge leaving WRITE:
- wr_addr SHALL increment by 4 (modulo 2^32);
- the remaining word count SHALL decrement;
- the FSM SHALL go to DATA if count>0, otherwise to DONE (or CHECK).
REQ-012 wr_en SHALL be 0 in every state other than WRITE.
REQ-013 In DONE, done=1 and cpu_hold=0. In ERR, error=1 and cpu_hold=0. done and error SHALL never both be 1.
REQ-014 start SHALL be ignored in LEN_LO, LEN_HI, DATA, WRITE and CHECK.
REQ-015 Cycles with byte_valid=0 SHALL stall the FSM indefinitely with no state change and no timeout.
REQ-016 wr_data SHALL hold its last value outside WRITE, and wr_addr SHALL hold between writes.

Reset
REQ-017 When reset=0 at a clock edge, the loader SHALL enter IDLE with:
- byte_ready=0, wr_en=0, cpu_hold=0, done=0, error=0;
- wr_addr=BASE_ADDR, wr_data=0;
- byte and word counters cleared.
REQ-018 Reset during any state, including WRITE, SHALL abort the load; a word not yet written SHALL be discarded, and no write SHALL occur in the reset cycle.
REQ-019 start sampled in the same cycle as reset=0 SHALL be ignored.

Configuration
REQ-020 When IMEM_LOADER_CHECKSUM_EN is defined:
- after the last word, or directly after the length when N=0, the FSM SHALL enter CHECK with byte_ready=1;
- CHECK SHALL accept one byte and compare it with the modulo-256 sum of all N*4 data bytes;
- on a match the FSM SHALL go to DONE, otherwise to ERR;
- the length bytes SHALL be excluded from the sum.
REQ-021 When IMEM_LOADER_CHECKSUM_EN is undefined, the CHECK state and the sum register SHALL NOT exist, and the transitions into CHECK SHALL go directly to DONE.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Basic load, no checksum: start; bytes 02 00 13 05 A0 00 93 05 10 00 -> wr_en pulses with (0x0, 0x00A00513) then (0x4, 0x00100593); then done=1, cpu_hold=0.
- Zero length: start; bytes 00 00 -> no wr_en; done=1 after 2 accepted bytes (after 3 bytes with checksum byte 00).
- Over length with MAX_WORDS=256: start; bytes 01 01 (N=257) -> error=1, byte_ready=0, no wr_en.
- Stall and reset: N=1, send 2 data bytes, drop byte_valid for 10 cycles, then reset=0 -> no wr_en, all outputs at reset values; a new start then loads correctly from BASE_ADDR.
- Checksum enabled: N=1, data 01 02 03 04, check byte 0A -> done=1. Same data with check byte 0B -> error=1 (wr_en still pulses once, with 0x04030201).
- Busy start and restart: start pulsed during DATA is ignored; start in DONE clears done and reloads from BASE_ADDR.
